// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction-fetch stage. Computes the next PC (`address`) that the program
// counter register samples every clock, fetches from instruction memory with a
// req/ready handshake and holds the IF/ID instruction register. Next-PC
// selection, highest priority first: interrupt vector, exception return (epc),
// branch/jump redirect, sequential. Also owns the EPC register and the
// in-handler flag.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   pc                   current program counter value
//   address              next PC (combinational)
//   imem_req/imem_addr   fetch request and address (held stable until ready)
//   imem_ready           memory accepts request, imem_rdata valid same cycle
//   imem_rdata           fetched instruction
//   stall                decode cannot consume instr this cycle
//   redirect/redirect_target   taken branch/jump and its destination
//   interrupt            level interrupt request
//   eret                 return from handler
//   instr/instr_pc/instr_valid IF/ID register
//   epc                  saved return address
//   int_ack              one-cycle pulse when an interrupt is taken
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          WIDTH       = 32,
    parameter int          INSTR_WIDTH = 32,
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned INT_VECTOR  = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       address,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_target,
    input  logic                   interrupt,
    input  logic                   eret,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [WIDTH-1:0]       instr_pc,
    output logic                   instr_valid,
    output logic [WIDTH-1:0]       epc,
    output logic                   int_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t           state;
    logic             in_handler;
    logic             int_pending;
    // A redirect or eret seen while a request is outstanding is parked here
    // until the handshake completes; an outstanding fetch is never aborted.
    logic             pend_valid;
    logic             pend_eret;
    logic [WIDTH-1:0] pend_target;

    logic             accept;
    logic             boundary;
    logic             int_req;
    logic             take;
    logic             eret_now;
    logic             redir_now;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] epc_next;

    // The request is a pure decode of the state register, so it drops the
    // moment reset pulls the state back to IDLE.
    assign imem_req  = (state == ISSUE);
    assign imem_addr = imem_req ? pc : '0;

    always_comb begin
        accept    = (state == ISSUE) && imem_ready;
        // Control flow may only change where no request is in flight.
        boundary  = (state != ISSUE) || imem_ready;
        int_req   = int_pending || (interrupt && !in_handler);
        take      = boundary && int_req;
        eret_now  = boundary && !take && (eret || (pend_valid && pend_eret));
        redir_now = boundary && !take && !eret_now &&
                    (redirect || (pend_valid && !pend_eret));
        // A live redirect is newer than a parked one.
        redir_tgt = redirect ? redirect_target : pend_target;

        // Return point for the handler: a pending control transfer wins, then
        // an instruction still parked in IF/ID, otherwise refetch pc.
        if (redirect || pend_valid)
            epc_next = redir_tgt;
        else if (instr_valid && stall)
            epc_next = instr_pc;
        else
            epc_next = pc;

        if (!reset)
            address = pc;
        else if (take)
            address = WIDTH'(INT_VECTOR);
        else if (eret_now)
            address = epc;
        else if (redir_now)
            address = redir_tgt;
        else if (accept)
            address = pc + WIDTH'(ADDR_STEP);
        else
            address = pc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            epc         <= '0;
            int_ack     <= 1'b0;
            in_handler  <= 1'b0;
            int_pending <= 1'b0;
            pend_valid  <= 1'b0;
            pend_eret   <= 1'b0;
            pend_target <= '0;
        end else begin
            int_ack <= 1'b0;
            if (interrupt && !in_handler)
                int_pending <= 1'b1;

            if (take) begin
                int_ack     <= 1'b1;
                in_handler  <= 1'b1;
                int_pending <= 1'b0;
                instr_valid <= 1'b0;
                epc         <= epc_next;
                pend_valid  <= 1'b0;
                pend_eret   <= 1'b0;
                state       <= ISSUE;
            end else if (eret_now) begin
                in_handler  <= 1'b0;
                instr_valid <= 1'b0;
                pend_valid  <= 1'b0;
                pend_eret   <= 1'b0;
                state       <= ISSUE;
            end else if (redir_now) begin
                // Any data arriving with this handshake is dropped.
                instr_valid <= 1'b0;
                pend_valid  <= 1'b0;
                pend_eret   <= 1'b0;
                state       <= ISSUE;
            end else if (!boundary) begin
                // Request outstanding: park control transfers. A parked eret
                // is not displaced by a later redirect.
                if (eret) begin
                    pend_valid  <= 1'b1;
                    pend_eret   <= 1'b1;
                    pend_target <= epc;
                end else if (redirect && !pend_eret) begin
                    pend_valid  <= 1'b1;
                    pend_eret   <= 1'b0;
                    pend_target <= redirect_target;
                end
            end else begin
                case (state)
                    IDLE: state <= ISSUE;
                    ISSUE: begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        // Decode is blocked: stop requesting and park in HOLD.
                        state       <= stall ? HOLD : ISSUE;
                    end
                    HOLD:    state <= stall ? HOLD : ISSUE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed walk through the fetch scenarios followed by a randomized run. The
// bench plays the program counter (pc follows the reference address) and the
// instruction memory, and compares every output each cycle against a
// behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        interrupt;
    logic        eret;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] epc;
    logic        int_ack;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .WIDTH(32), .INSTR_WIDTH(32), .ADDR_STEP(1), .INT_VECTOR(100)
    ) dut (
        .clock(clock), .reset(reset), .pc(pc), .address(address),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .interrupt(interrupt), .eret(eret),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .epc(epc), .int_ack(int_ack)
    );

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_FETCH, P_HOLD} phase_t;
    phase_t      ph;
    logic [31:0] m_pc, m_instr, m_ipc, m_epc, m_pt, e_addr;
    bit          m_iv, m_ack, m_inh, m_ip, m_pv, m_pe;

    // DUT values sampled in the most recent step, for scenario-specific checks
    logic [31:0] last_addr, last_iaddr;
    logic        last_req;

    task automatic model_reset();
        ph = P_IDLE;
        m_instr = 0; m_ipc = 0; m_epc = 0; m_pt = 0;
        m_iv = 0; m_ack = 0; m_inh = 0; m_ip = 0; m_pv = 0; m_pe = 0;
    endtask

    // One clock of the fetch stage from the current inputs: sets e_addr and
    // advances the model to its post-edge state.
    task automatic model_cycle();
        bit in_flight = (ph == P_FETCH) && !imem_ready;
        bit want_int  = m_ip || (interrupt && !m_inh);
        m_ack = 0;
        if (interrupt && !m_inh) m_ip = 1;
        if (in_flight) begin
            e_addr = m_pc;
            if (eret) begin
                m_pv = 1; m_pe = 1; m_pt = m_epc;
            end else if (redirect && !m_pe) begin
                m_pv = 1; m_pt = redirect_target;
            end
        end else begin
            if (want_int) begin
                if (redirect)            m_epc = redirect_target;
                else if (m_pv)           m_epc = m_pt;
                else if (m_iv && stall)  m_epc = m_ipc;
                else                     m_epc = m_pc;
                e_addr = 100; m_ack = 1; m_inh = 1; m_ip = 0; m_iv = 0;
                ph = P_FETCH;
            end else if (eret || (m_pv && m_pe)) begin
                e_addr = m_epc; m_inh = 0; m_iv = 0; ph = P_FETCH;
            end else if (redirect || m_pv) begin
                e_addr = redirect ? redirect_target : m_pt; m_iv = 0; ph = P_FETCH;
            end else if (ph == P_FETCH) begin
                m_instr = imem_rdata; m_ipc = m_pc; m_iv = 1;
                e_addr = m_pc + 32'd1;
                ph = stall ? P_HOLD : P_FETCH;
            end else begin
                e_addr = m_pc;
                ph = (ph == P_HOLD && stall) ? P_HOLD : P_FETCH;
            end
            m_pv = 0; m_pe = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are set at posedge+1; sample at posedge+3, then advance.
    task automatic step();
        #2;
        chk("instr",       instr,            m_instr);
        chk("instr_pc",    instr_pc,         m_ipc);
        chk("instr_valid", 32'(instr_valid), 32'(m_iv));
        chk("epc",         epc,              m_epc);
        chk("int_ack",     32'(int_ack),     32'(m_ack));
        chk("imem_req",    32'(imem_req),    32'(ph == P_FETCH));
        chk("imem_addr",   imem_addr,        (ph == P_FETCH) ? m_pc : 32'd0);
        last_addr = address; last_iaddr = imem_addr; last_req = imem_req;
        model_cycle();
        chk("address",     address,          e_addr);
        @(posedge clock);
        #1;
        m_pc = e_addr;
        pc   = m_pc;
    endtask

    task automatic drive(input bit rdy, input bit st, input bit rd,
                         input logic [31:0] tg, input bit it, input bit er);
        imem_ready = rdy; stall = st; redirect = rd; redirect_target = tg;
        interrupt = it; eret = er; imem_rdata = 32'hA0 + pc;
        step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr",     instr,            32'd0);
        chk("rst_instr_pc",  instr_pc,         32'd0);
        chk("rst_valid",     32'(instr_valid), 32'd0);
        chk("rst_epc",       epc,              32'd0);
        chk("rst_int_ack",   32'(int_ack),     32'd0);
        chk("rst_req",       32'(imem_req),    32'd0);
        chk("rst_imem_addr", imem_addr,        32'd0);
        chk("rst_address",   address,          pc);
    endtask

    initial begin
        reset = 1'b1; pc = 0; m_pc = 0; imem_ready = 0; imem_rdata = 0; stall = 0;
        redirect = 0; redirect_target = 0; interrupt = 0; eret = 0;
        model_reset();
        #1 reset = 1'b0;
        #2;
        chk_reset_outputs();
        @(posedge clock); #1 reset = 1'b1;

        // sequential fetch 0..3 after one idle cycle
        drive(1, 0, 0, 0, 0, 0);
        chk("idle_req", 32'(last_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("seq_iaddr", last_iaddr, 32'(i));
        end
        chk("seq_ipc", instr_pc, 32'd3);

        // three wait states at pc=4
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("wait_req",   32'(last_req), 32'd1);
            chk("wait_iaddr", last_iaddr,    32'd4);
            chk("wait_addr",  last_addr,     32'd4);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("wait_done_addr", last_addr, 32'd5);

        // stall holding instr_pc=6
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk("stall_addr", last_addr, 32'd7);
        drive(1, 1, 0, 0, 0, 0);
        chk("hold_req",   32'(last_req), 32'd0);
        chk("hold_addr",  last_addr,     32'd7);
        chk("hold_ipc",   instr_pc,      32'd6);
        chk("hold_instr", instr,         32'hA6);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("resume_req",   32'(last_req), 32'd1);
        chk("resume_iaddr", last_iaddr,    32'd7);

        // redirect while the request at 8 is outstanding
        drive(0, 0, 1, 32'h40, 0, 0);
        chk("pend_addr", last_addr, 32'd8);
        drive(0, 0, 0, 0, 0, 0);
        chk("pend_iaddr", last_iaddr, 32'd8);
        drive(1, 0, 0, 0, 0, 0);
        chk("pend_target", last_addr, 32'h40);
        chk("pend_drop", 32'(instr_valid), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk("pend_fetch", last_iaddr, 32'h40);

        // sequential wrap at the top of the address space
        drive(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("wrap_addr", last_addr, 32'd0);

        // interrupt at pc=5, ignored while in handler, eret back, retaken
        drive(1, 0, 1, 32'd5, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        chk("int_vec",  last_addr,    32'd100);
        chk("int_ack1", 32'(int_ack), 32'd1);
        chk("int_epc",  epc,          32'd5);
        drive(1, 0, 0, 0, 1, 0);
        chk("int_ignored", last_addr, 32'd101);
        chk("int_ack0", 32'(int_ack), 32'd0);
        drive(1, 0, 0, 0, 0, 1);
        chk("eret_addr", last_addr, 32'd5);
        drive(1, 0, 0, 0, 1, 0);
        chk("int_again", last_addr, 32'd100);
        drive(1, 0, 0, 0, 0, 1);
        chk("eret_again", last_addr, 32'd5);

        // reset during an outstanding request
        drive(0, 0, 0, 0, 0, 0);
        imem_ready = 0;
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        pc = 0; m_pc = 0;
        @(posedge clock); #1 reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        chk("post_rst_idle", 32'(last_req), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk("post_rst_issue", 32'(last_req), 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            imem_ready      = ($urandom_range(3) != 0);
            stall           = ($urandom_range(3) == 0);
            redirect        = ($urandom_range(9) == 0);
            redirect_target = 32'($urandom_range(255));
            interrupt       = ($urandom_range(19) == 0);
            eret            = ($urandom_range(19) == 0);
            imem_rdata      = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
